pp_pipeline_accel_mul_arb: RTL and testbench

PP_PIPELINE_ACCEL_MUL_ARB -- requirements
Module: pp_pipeline_accel_mul_arb

---
 rtl/pp_pipeline_accel_mul_arb.sv | 85 ++++++++
 tb/tb_pp_pipeline_accel_mul_arb.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pp_pipeline_accel_mul_arb.sv
// Two-requester round-robin front end for a shared pipelined multiplier.
// A tag pipeline tracks which requester owns each in-flight product so results return in order.
module pp_pipeline_accel_mul_arb #(
  parameter int MUL_LATENCY = 3,
  parameter int A_W         = 20,
  parameter int B_W         = 11,
  parameter int P_W         = 31
) (
  input  logic           ap_clk,
  input  logic           ap_rst_n,
  input  logic           req0_valid,
  input  logic           req1_valid,
  output logic           req0_ready,
  output logic           req1_ready,
  input  logic [A_W-1:0] req0_a,
  input  logic [A_W-1:0] req1_a,
  input  logic [B_W-1:0] req0_b,
  input  logic [B_W-1:0] req1_b,
  output logic           res0_valid,
  output logic           res1_valid,
  input  logic           res0_ready,
  input  logic           res1_ready,
  output logic [P_W-1:0] res_data,
  output logic           mul_ce,
  output logic [A_W-1:0] mul_din0,
  output logic [B_W-1:0] mul_din1,
  input  logic [P_W-1:0] mul_dout,
  output logic           busy
);

  // Handshakes: a transfer happens in a cycle where valid and ready are both high.
  // Ready never waits on anything but mul_ce and the grant; valid is not sticky.

  logic [MUL_LATENCY-1:0] vld;
  logic [MUL_LATENCY-1:0] own;
  logic                   prio;  // 0: requester 0 wins the next contention
  logic                   last_ready;
  logic                   issue_ok;
  logic                   gnt0;
  logic                   gnt1;

  always_comb begin
    last_ready = own[MUL_LATENCY-1] ? res1_ready : res0_ready;
    // Reset forces the multiplier to keep clocking so stale products flush out.
    mul_ce     = !ap_rst_n || !(vld[MUL_LATENCY-1] && !last_ready);
    issue_ok   = ap_rst_n && mul_ce;
    gnt0       = issue_ok && req0_valid && (!req1_valid || !prio);
    gnt1       = issue_ok && req1_valid && (!req0_valid || prio);
    req0_ready = gnt0;
    req1_ready = gnt1;
    mul_din0   = '0;
    mul_din1   = '0;
    if (gnt0) begin
      mul_din0 = req0_a;
      mul_din1 = req0_b;
    end else if (gnt1) begin
      mul_din0 = req1_a;
      mul_din1 = req1_b;
    end
    res0_valid = ap_rst_n && vld[MUL_LATENCY-1] && !own[MUL_LATENCY-1];
    res1_valid = ap_rst_n && vld[MUL_LATENCY-1] &&  own[MUL_LATENCY-1];
    res_data   = mul_dout;
    busy       = |vld;
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      vld  <= '0;
      own  <= '0;
      prio <= 1'b0;
    end else begin
      if (mul_ce) begin
        for (int i = MUL_LATENCY - 1; i > 0; i--) begin
          vld[i] <= vld[i-1];
          own[i] <= own[i-1];
        end
        vld[0] <= gnt0 || gnt1;
        own[0] <= gnt1;
      end
      // The requester just served yields priority to the other one.
      if (gnt0 || gnt1) prio <= gnt0;
    end
  end

endmodule

// File: tb/tb_pp_pipeline_accel_mul_arb.sv
// Directed bench for the multiplier arbiter with a behavioural ce-gated multiplier
// and per-requester expected-product queues for the random-gap phase.
module tb_pp_pipeline_accel_mul_arb;

  localparam int L   = 3;
  localparam int A_W = 20;
  localparam int B_W = 11;
  localparam int P_W = 31;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           req0_valid, req1_valid, req0_ready, req1_ready;
  logic [A_W-1:0] a0, a1;
  logic [B_W-1:0] b0, b1;
  logic           res0_valid, res1_valid, res0_ready, res1_ready;
  logic [P_W-1:0] res_data;
  logic           mul_ce;
  logic [A_W-1:0] mul_din0;
  logic [B_W-1:0] mul_din1;
  logic [P_W-1:0] mul_dout;
  logic           busy;

  int tests = 0;
  int fails = 0;
  logic [P_W-1:0] exp0_q[$];
  logic [P_W-1:0] exp1_q[$];

  always #5 clk = ~clk;

  pp_pipeline_accel_mul_arb #(.MUL_LATENCY(L), .A_W(A_W), .B_W(B_W), .P_W(P_W)) dut (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(a0), .req1_a(a1), .req0_b(b0), .req1_b(b1),
    .res0_valid(res0_valid), .res1_valid(res1_valid),
    .res0_ready(res0_ready), .res1_ready(res1_ready),
    .res_data(res_data), .mul_ce(mul_ce),
    .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
    .busy(busy)
  );

  // Shared multiplier: L ce-qualified stages from operands to product.
  logic [P_W-1:0] p_q [L];
  always @(posedge clk) begin
    if (mul_ce) begin
      p_q[0] <= P_W'(mul_din0) * P_W'(mul_din1);
      for (int i = 1; i < L; i++) p_q[i] <= p_q[i-1];
    end
  end
  assign mul_dout = p_q[L-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Four cycles of two-way contention, then drain; first = requester granted first.
  task automatic contention(input bit first);
    logic e;
    a0 = 20'd5; b0 = 11'd2; a1 = 20'd7; b1 = 11'd3;
    for (int i = 0; i < 7; i++) begin
      req0_valid = (i < 4);
      req1_valid = (i < 4);
      #1;
      if (i < 4) begin
        e = ((i % 2) == 0) ^ first;
        chk("cont_rdy0", req0_ready, e);
        chk("cont_rdy1", req1_ready, !e);
      end
      if (i >= 3) begin
        e = (((i - 3) % 2) == 0) ^ first;
        chk("cont_res0_valid", res0_valid, e);
        chk("cont_res1_valid", res1_valid, !e);
        chk("cont_res_data", res_data, e ? 64'd10 : 64'd21);
      end else begin
        chk("cont_no_res", res0_valid | res1_valid, 0);
      end
      adv();
    end
  endtask

  initial begin
    logic [63:0] prod;
    rst_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b0;
    a0 = '0; a1 = '0; b0 = '0; b1 = '0;
    res0_ready = 1'b1; res1_ready = 1'b1;

    // Reset behaviour
    adv();
    chk("rst_rdy0", req0_ready, 0);
    chk("rst_ce", mul_ce, 1);
    adv();
    chk("rst_busy", busy, 0);
    chk("rst_res0_valid", res0_valid, 0);
    rst_n = 1'b1; req0_valid = 1'b0;
    adv();

    // Single operation
    req0_valid = 1'b1; a0 = 20'd1000; b0 = 11'd3;
    #1;
    chk("single_rdy0", req0_ready, 1);
    chk("single_rdy1", req1_ready, 0);
    chk("single_din0", mul_din0, 1000);
    chk("single_din1", mul_din1, 3);
    adv();
    req0_valid = 1'b0;
    #1;
    chk("single_busy", busy, 1);
    chk("single_idle_din0", mul_din0, 0);
    chk("single_early_t1", res0_valid, 0);
    adv();
    chk("single_early_t2", res0_valid, 0);
    adv();
    chk("single_res_valid", res0_valid, 1);
    chk("single_res_data", res_data, 3000);
    adv();
    chk("single_done_valid", res0_valid, 0);
    chk("single_done_busy", busy, 0);

    // Requester 0 was served last, so requester 1 wins first here
    contention(1'b1);

    // Max operands: (2^20-1)*(2^11-1) = 2146433025, unsigned
    req0_valid = 1'b1; a0 = 20'hFFFFF; b0 = 11'h7FF;
    #1;
    chk("max_rdy0", req0_ready, 1);
    adv();
    req0_valid = 1'b0;
    adv();
    adv();
    chk("max_res_valid", res0_valid, 1);
    chk("max_res_data", res_data, 64'd2146433025);
    adv();

    // Backpressure on requester 1
    res1_ready = 1'b0;
    req1_valid = 1'b1; a1 = 20'd100; b1 = 11'd4;
    #1; chk("bp_g1", req1_ready, 1);
    adv();
    req1_valid = 1'b0; req0_valid = 1'b1; a0 = 20'd6; b0 = 11'd7;
    #1; chk("bp_g0", req0_ready, 1);
    adv();
    req0_valid = 1'b0; req1_valid = 1'b1; a1 = 20'd9; b1 = 11'd9;
    #1; chk("bp_g2", req1_ready, 1);
    adv();
    req1_valid = 1'b0; req0_valid = 1'b1; a0 = 20'd2; b0 = 11'd2;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("bp_stall_ce", mul_ce, 0);
      chk("bp_stall_rdy0", req0_ready, 0);
      chk("bp_stall_valid", res1_valid, 1);
      chk("bp_stall_data", res_data, 400);
      chk("bp_stall_busy", busy, 1);
      adv();
    end
    res1_ready = 1'b1;
    #1;
    chk("bp_release_ce", mul_ce, 1);
    chk("bp_release_rdy0", req0_ready, 1);
    chk("bp_release_valid", res1_valid, 1);
    chk("bp_release_data", res_data, 400);
    adv();
    req0_valid = 1'b0;
    #1;
    chk("bp_order1_valid", res0_valid, 1);
    chk("bp_order1_data", res_data, 42);
    adv();
    chk("bp_order2_valid", res1_valid, 1);
    chk("bp_order2_data", res_data, 81);
    adv();
    chk("bp_order3_valid", res0_valid, 1);
    chk("bp_order3_data", res_data, 4);
    adv();

    // Reset mid-flight
    req0_valid = 1'b1; a0 = 20'd3; b0 = 11'd3;
    adv(); adv(); adv();
    rst_n = 1'b0; req1_valid = 1'b1;
    #1;
    chk("midrst_rdy0", req0_ready, 0);
    chk("midrst_rdy1", req1_ready, 0);
    chk("midrst_ce", mul_ce, 1);
    chk("midrst_res0_valid", res0_valid, 0);
    adv();
    rst_n = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    chk("midrst_busy", busy, 0);
    contention(1'b0);

    // Random idle gaps with both result channels always ready
    for (int i = 0; i < 80; i++) begin
      req0_valid = (i < 70) ? 1'($urandom_range(0, 1)) : 1'b0;
      req1_valid = (i < 70) ? 1'($urandom_range(0, 1)) : 1'b0;
      a0 = A_W'($urandom_range(0, (1 << A_W) - 1));
      a1 = A_W'($urandom_range(0, (1 << A_W) - 1));
      b0 = B_W'($urandom_range(0, (1 << B_W) - 1));
      b1 = B_W'($urandom_range(0, (1 << B_W) - 1));
      #1;
      chk("rand_onehot_rdy", req0_ready & req1_ready, 0);
      if (req0_ready) begin
        prod = 64'(a0) * 64'(b0);
        exp0_q.push_back(prod[P_W-1:0]);
      end
      if (req1_ready) begin
        prod = 64'(a1) * 64'(b1);
        exp1_q.push_back(prod[P_W-1:0]);
      end
      if (res0_valid) begin
        if (exp0_q.size() == 0) chk("rand_res0_extra", 1, 0);
        else chk("rand_res0_data", res_data, exp0_q.pop_front());
      end
      if (res1_valid) begin
        if (exp1_q.size() == 0) chk("rand_res1_extra", 1, 0);
        else chk("rand_res1_data", res_data, exp1_q.pop_front());
      end
      adv();
    end
    chk("rand_res0_left", exp0_q.size(), 0);
    chk("rand_res1_left", exp1_q.size(), 0);
    chk("rand_busy_end", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
